// File: rtl/mfp_timer_pkg.sv
// Shared encodings and the prescale table for the MFP-style timer channel.
package mfp_timer_pkg;

    localparam logic [3:0] MODE_STOP       = 4'd0;
    localparam logic [3:0] MODE_EVENT      = 4'd8;
    localparam logic [3:0] MODE_PULSE_BASE = 4'd8;

    localparam int CTRL_MODE_MSB = 3;
    localparam int CTRL_CLR_TO   = 4;
    localparam int CTRL_ONE_SHOT = 5;

    // What drives a count for the current mode.
    typedef enum logic [1:0] {
        CNT_NONE  = 2'd0,
        CNT_DELAY = 2'd1,
        CNT_EVENT = 2'd2,
        CNT_PULSE = 2'd3
    } cnt_src_e;

    function automatic cnt_src_e mode_src(input logic [3:0] mode);
        cnt_src_e src;
        if (mode == MODE_STOP)
            src = CNT_NONE;
        else if (mode == MODE_EVENT)
            src = CNT_EVENT;
        else if (mode > MODE_PULSE_BASE)
            src = CNT_PULSE;
        else
            src = CNT_DELAY;
        return src;
    endfunction

    // Prescale select (mode[2:0]) to terminal count N-1.
    function automatic logic [7:0] prescale_nm1(input logic [2:0] sel);
        logic [7:0] nm1;
        case (sel)
            3'd1:    nm1 = 8'd3;
            3'd2:    nm1 = 8'd9;
            3'd3:    nm1 = 8'd15;
            3'd4:    nm1 = 8'd49;
            3'd5:    nm1 = 8'd63;
            3'd6:    nm1 = 8'd99;
            3'd7:    nm1 = 8'd199;
            default: nm1 = 8'd0;
        endcase
        return nm1;
    endfunction

endpackage

// File: rtl/mfp_timer_prescaler.sv
// Timer-clock prescaler: counts XCLK_EN cycles 0..div and emits one tick per wrap.
module mfp_timer_prescaler
#(
    parameter int PRE_W = 8
)
(
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_xclk_en,
    input  logic             i_run,
    input  logic             i_clr,
    input  logic [PRE_W-1:0] i_div,
    output logic             o_tick
);

    logic [PRE_W-1:0] r_pre_cnt;
    logic             w_hit;

    assign w_hit  = (r_pre_cnt == i_div);
    assign o_tick = i_xclk_en & w_hit & i_run;

    // Prescale counter; parked at zero while stopped or on any control write.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pre_cnt <= '0;
        end else if (i_clr || !i_run) begin
            r_pre_cnt <= '0;
        end else if (i_xclk_en) begin
            if (w_hit)
                r_pre_cnt <= '0;
            else
                r_pre_cnt <= r_pre_cnt + PRE_W'(1);
        end
    end

endmodule

// File: rtl/mfp_timer_gen.sv
// One MFP timer channel: reloading down-counter with delay, pulse-width,
// event and one-shot operation, T_I synchroniser and CPU readback latch.
module mfp_timer_gen
    import mfp_timer_pkg::*;
#(
    parameter int CNT_W       = 8,
    parameter int PRE_W       = 8,
    parameter int SYNC_STAGES = 2
)
(
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clk_en,
    input  logic             i_xclk_en,
    input  logic             i_ds,
    input  logic             i_dat_we,
    input  logic [CNT_W-1:0] i_dat_i,
    output logic [CNT_W-1:0] o_dat_o,
    input  logic             i_ctrl_we,
    input  logic [5:0]       i_ctrl_i,
    output logic [4:0]       o_ctrl_o,
    input  logic             i_t_i,
    input  logic             i_t_pol,
    output logic             o_t_o,
    output logic             o_t_o_pulse,
    output logic             o_pulse_mode,
    output logic             o_event_mode,
    output logic             o_running,
    output logic [CNT_W-1:0] o_set_data_out
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [3:0]             r_mode;
    logic                   r_one_shot;
    logic [CNT_W-1:0]       r_data;
    logic [CNT_W-1:0]       r_counter;
    logic [CNT_W-1:0]       r_dat_o;
    logic                   r_t_o;
    logic                   r_t_o_pulse;
    logic                   r_count_q;
    logic                   r_ds_q;
    logic                   r_trig_d;
    logic [SYNC_STAGES-1:0] r_sync;

    logic                   w_run;
    cnt_src_e               w_src;
    logic [PRE_W-1:0]       w_div;
    logic                   w_tick;
    logic                   w_trig_s;
    logic                   w_edge;
    logic                   w_count;

    assign w_run    = (r_mode != MODE_STOP);
    assign w_src    = mode_src(r_mode);
    assign w_div    = PRE_W'(prescale_nm1(r_mode[2:0]));
    assign w_trig_s = r_sync[SYNC_STAGES-1] ^ ~i_t_pol;
    assign w_edge   = i_clk_en & w_trig_s & ~r_trig_d;

    mfp_timer_prescaler #(.PRE_W(PRE_W)) u_prescaler (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_xclk_en (i_xclk_en),
        .i_run     (w_run),
        .i_clr     (i_ctrl_we),
        .i_div     (w_div),
        .o_tick    (w_tick)
    );

    // Select the count source for the active mode.
    always_comb begin
        w_count = 1'b0;
        case (w_src)
            CNT_DELAY: w_count = w_tick;
            CNT_PULSE: w_count = w_tick & w_trig_s;
            CNT_EVENT: w_count = w_edge;
            default:   w_count = 1'b0;
        endcase
    end

    // T_I synchroniser and the CLK_EN-sampled copy used for edge detection.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync   <= '0;
            r_trig_d <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_t_i};
            if (i_clk_en)
                r_trig_d <= w_trig_s;
        end
    end

    // Register the count request so the counter sees a clean one-cycle strobe.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_count_q <= 1'b0;
        else
            r_count_q <= w_count;
    end

    // Counter, reload/timeout and CPU register writes; later writes take priority.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_counter   <= '0;
            r_data      <= '0;
            r_mode      <= MODE_STOP;
            r_one_shot  <= 1'b0;
            r_t_o       <= 1'b0;
            r_t_o_pulse <= 1'b0;
        end else begin
            r_t_o_pulse <= 1'b0;
            if (r_count_q) begin
                if (r_counter == CNT_ONE) begin
                    r_counter   <= i_dat_we ? i_dat_i : r_data;
                    r_t_o       <= ~r_t_o;
                    r_t_o_pulse <= 1'b1;
                    if (r_one_shot)
                        r_mode <= MODE_STOP;
                end else begin
                    r_counter <= r_counter - CNT_ONE;
                end
            end
            if (i_dat_we) begin
                r_data <= i_dat_i;
                if (!w_run)
                    r_counter <= i_dat_i;
            end
            if (i_ctrl_we) begin
                r_mode     <= i_ctrl_i[CTRL_MODE_MSB:0];
                r_one_shot <= i_ctrl_i[CTRL_ONE_SHOT];
                if (i_ctrl_i[CTRL_CLR_TO])
                    r_t_o <= 1'b0;
            end
        end
    end

    // Snapshot the counter on the rising edge of the CPU data strobe.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ds_q  <= 1'b0;
            r_dat_o <= '0;
        end else begin
            r_ds_q <= i_ds;
            if (i_ds && !r_ds_q)
                r_dat_o <= r_counter;
        end
    end

    assign o_dat_o        = r_dat_o;
    assign o_ctrl_o       = {r_one_shot, r_mode};
    assign o_t_o          = r_t_o;
    assign o_t_o_pulse    = r_t_o_pulse;
    assign o_pulse_mode   = (w_src == CNT_PULSE);
    assign o_event_mode   = (w_src == CNT_EVENT);
    assign o_running      = w_run;
    assign o_set_data_out = r_data;

endmodule

// File: tb/tb_mfp_timer_gen.sv
// Bench for mfp_timer_gen: mode-decode table plus timed sequences; every
// expected timeout cycle is queued up front and checked as pulses appear.
module tb_mfp_timer_gen;

    localparam int CNT_W = 8;
    localparam int PRE_W = 8;
    localparam int SYNC_STAGES = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             i_clk_en = 1'b1;
    logic             i_xclk_en = 1'b1;
    logic             i_ds = 1'b0;
    logic             i_dat_we = 1'b0;
    logic [CNT_W-1:0] i_dat_i = '0;
    logic [CNT_W-1:0] o_dat_o;
    logic             i_ctrl_we = 1'b0;
    logic [5:0]       i_ctrl_i = '0;
    logic [4:0]       o_ctrl_o;
    logic             i_t_i = 1'b0;
    logic             i_t_pol = 1'b1;
    logic             o_t_o;
    logic             o_t_o_pulse;
    logic             o_pulse_mode;
    logic             o_event_mode;
    logic             o_running;
    logic [CNT_W-1:0] o_set_data_out;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int exp_q[$];
    bit ce_mode = 1'b0;

    typedef struct {
        logic [5:0] ctrl;
        logic [7:0] exp;   // {ctrl_o, pulse_mode, event_mode, running}
    } vec_t;

    mfp_timer_gen #(.CNT_W(CNT_W), .PRE_W(PRE_W), .SYNC_STAGES(SYNC_STAGES)) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_clk_en       (i_clk_en),
        .i_xclk_en      (i_xclk_en),
        .i_ds           (i_ds),
        .i_dat_we       (i_dat_we),
        .i_dat_i        (i_dat_i),
        .o_dat_o        (o_dat_o),
        .i_ctrl_we      (i_ctrl_we),
        .i_ctrl_i       (i_ctrl_i),
        .o_ctrl_o       (o_ctrl_o),
        .i_t_i          (i_t_i),
        .i_t_pol        (i_t_pol),
        .o_t_o          (o_t_o),
        .o_t_o_pulse    (o_t_o_pulse),
        .o_pulse_mode   (o_pulse_mode),
        .o_event_mode   (o_event_mode),
        .o_running      (o_running),
        .o_set_data_out (o_set_data_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d (cyc %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic goto(input int c);
        if (cyc > c) begin
            total++;
            bad++;
            $display("FAIL goto_late actual=%0d expected=%0d", cyc, c);
        end
        while (cyc < c) step(1);
    endtask

    task automatic wr_ctrl(input logic [5:0] v);
        i_ctrl_i  = v;
        i_ctrl_we = 1'b1;
        step(1);
        i_ctrl_we = 1'b0;
    endtask

    task automatic wr_data(input logic [CNT_W-1:0] v);
        i_dat_i  = v;
        i_dat_we = 1'b1;
        step(1);
        i_dat_we = 1'b0;
    endtask

    // Latches the counter value of the current cycle, returns it next cycle.
    task automatic ds_read(output logic [CNT_W-1:0] v);
        i_ds = 1'b1;
        step(1);
        v = o_dat_o;
        i_ds = 1'b0;
        step(1);
    endtask

    // Cycle in which T_O_PULSE is high for an active T_I change driven in cycle c
    // with CLK_EN high only on cycles divisible by 4.
    function automatic int ev_pulse(input int c);
        int m;
        m = c + SYNC_STAGES;
        while (m % 4 != 0) m++;
        return m + 2;
    endfunction

    // Scoreboard: every pulse must match the oldest queued expected cycle.
    initial begin
        forever begin
            int e;
            @(negedge clk);
            if (o_t_o_pulse === 1'b1) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sb_unexpected_pulse actual=1 expected=0 (cyc %0d)", cyc);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_pulse_cycle", cyc, e);
                end
            end
        end
    end

    initial begin
        i_clk_en = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            i_clk_en = ce_mode ? (cyc % 4 == 0) : 1'b1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t vecs[8];
        logic [CNT_W-1:0] rd;
        int k;

        vecs[0] = '{6'h00, {5'b00000, 3'b000}};
        vecs[1] = '{6'h01, {5'b00001, 3'b001}};
        vecs[2] = '{6'h07, {5'b00111, 3'b001}};
        vecs[3] = '{6'h08, {5'b01000, 3'b011}};
        vecs[4] = '{6'h09, {5'b01001, 3'b101}};
        vecs[5] = '{6'h0F, {5'b01111, 3'b101}};
        vecs[6] = '{6'h23, {5'b10011, 3'b001}};
        vecs[7] = '{6'h10, {5'b00000, 3'b000}};

        // Reset state
        step(3);
        rst_n = 1'b1;
        step(2);
        chk("rst_t_o", o_t_o, 0);
        chk("rst_pulse", o_t_o_pulse, 0);
        chk("rst_dat_o", o_dat_o, 0);
        chk("rst_ctrl_o", o_ctrl_o, 0);
        chk("rst_flags", {o_pulse_mode, o_event_mode, o_running}, 0);
        chk("rst_data", o_set_data_out, 0);

        // Mode decode table (counter is 0, writes clear the prescaler: no timeouts)
        for (int i = 0; i < 8; i++) begin
            wr_ctrl(vecs[i].ctrl);
            chk("mode_table", {o_ctrl_o, o_pulse_mode, o_event_mode, o_running}, vecs[i].exp);
        end

        // Delay mode /4, data 3: pulses every 12 CLK, readback 3,2,1
        wr_data(8'd3);
        k = cyc;
        exp_q.push_back(k + 14);
        exp_q.push_back(k + 26);
        exp_q.push_back(k + 38);
        wr_ctrl(6'h01);
        goto(k + 3);  ds_read(rd); chk("delay_rd3", rd, 3);
        goto(k + 7);  ds_read(rd); chk("delay_rd2", rd, 2);
        goto(k + 11); ds_read(rd); chk("delay_rd1", rd, 1);
        goto(k + 15); chk("delay_t_o_1", o_t_o, 1);
        goto(k + 27); chk("delay_t_o_2", o_t_o, 0);
        goto(k + 39); chk("delay_t_o_3", o_t_o, 1);
        wr_ctrl(6'h10);
        chk("delay_t_o_clr", o_t_o, 0);
        chk("delay_sb_drain", exp_q.size(), 0);

        // Data 0 means 256 counts: period 1024 CLK, wrap 0 -> 255
        wr_data(8'd0);
        k = cyc;
        exp_q.push_back(k + 1026);
        exp_q.push_back(k + 2050);
        wr_ctrl(6'h01);
        goto(k + 7); ds_read(rd); chk("wrap_rd255", rd, 255);
        goto(k + 2051);
        wr_ctrl(6'h10);
        chk("wrap_sb_drain", exp_q.size(), 0);

        // Event mode, active-low T_I, CLK_EN every 4th cycle
        ce_mode = 1'b1;
        i_t_pol = 1'b0;
        i_t_i   = 1'b1;
        step(12);
        wr_data(8'd2);
        wr_ctrl(6'h08);
        step(4);
        i_t_i = 1'b0;
        step(12);
        i_t_i = 1'b1;
        step(12);
        ds_read(rd); chk("event_rise_ignored", rd, 1);
        exp_q.push_back(ev_pulse(cyc));
        i_t_i = 1'b0;
        step(12);
        chk("event_sb_drain", exp_q.size(), 0);
        wr_ctrl(6'h10);
        ce_mode = 1'b0;
        i_t_pol = 1'b1;
        i_t_i   = 1'b0;
        step(8);

        // Pulse mode 9: only ticks while T_I is high count
        wr_data(8'd20);
        wr_ctrl(6'h09);
        step(20);
        ds_read(rd); chk("pulse_frozen_pre", rd, 20);
        i_t_i = 1'b1;
        step(40);
        i_t_i = 1'b0;
        step(10);
        ds_read(rd); chk("pulse_count", rd, 10);
        step(20);
        ds_read(rd); chk("pulse_frozen_post", rd, 10);
        wr_ctrl(6'h10);

        // One-shot, mode 1, data 2
        wr_data(8'd2);
        k = cyc;
        exp_q.push_back(k + 10);
        wr_ctrl(6'h21);
        goto(k + 9);  chk("oneshot_running_before", o_running, 1);
        goto(k + 10); chk("oneshot_running_after", o_running, 0);
        goto(k + 20); ds_read(rd); chk("oneshot_hold", rd, 2);
        chk("oneshot_sb_drain", exp_q.size(), 0);
        wr_ctrl(6'h10);

        // DAT_WE while running, then DAT_WE on a reload, then T_O clear on a toggle
        wr_data(8'd3);
        k = cyc;
        exp_q.push_back(k + 14);
        exp_q.push_back(k + 34);
        exp_q.push_back(k + 62);
        wr_ctrl(6'h01);
        goto(k + 2);  wr_data(8'd5);
        chk("datwe_data", o_set_data_out, 5);
        goto(k + 7);  ds_read(rd); chk("datwe_run_no_load", rd, 2);
        goto(k + 33); wr_data(8'd7);
        goto(k + 35); ds_read(rd); chk("coincident_reload", rd, 7);
        goto(k + 61); wr_ctrl(6'h11);
        chk("clr_wins", o_t_o, 0);
        wr_ctrl(6'h10);
        chk("corner_sb_drain", exp_q.size(), 0);

        // Asynchronous reset mid-count
        wr_data(8'd3);
        k = cyc;
        exp_q.push_back(k + 14);
        wr_ctrl(6'h01);
        goto(k + 20);
        chk("pre_reset_t_o", o_t_o, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_t_o", o_t_o, 0);
        chk("async_rst_running", o_running, 0);
        chk("async_rst_regs", {o_ctrl_o, o_set_data_out, o_dat_o}, 0);
        step(2);
        rst_n = 1'b1;
        step(30);
        chk("post_reset_stopped", o_running, 0);
        ds_read(rd); chk("post_reset_counter", rd, 0);
        chk("reset_sb_drain", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mfp_timer_gen.md
# mfp_timer_gen

Parametrised next-generation MFP68901-style timer channel: a CNT_W-bit reloading down-counter with delay, pulse-width and event modes, plus a one-shot mode, selectable trigger polarity and a synchronous timer-clock enable. One instance per timer channel sits inside the MFP. It feeds T_O/T_O_PULSE to the interrupt and serial-baud logic, and returns the counter snapshot to the CPU read mux.

## Interface
- CNT_W, 8, data/counter width; a data value of 0 means 2^CNT_W counts.
- PRE_W, 8, prescaler counter width; must hold 199.
- SYNC_STAGES, 2, T_I synchroniser depth (≥2).
- CLK  in  1  system clock; one clock only.
- RST_N  in  1  asynchronous, active-low reset.
- CLK_EN  in  1  MFP clock-enable; T_I is sampled only on CLK_EN cycles.
- XCLK_EN  in  1  one-CLK-wide timer-clock enable, generated upstream in the CLK domain.
- DS  in  1  CPU data strobe; its rising edge latches the readback value.
- DAT_WE  in  1  data register write strobe.
- DAT_I  in  CNT_W  data register write value.
- DAT_O  out  CNT_W  counter snapshot.
- CTRL_WE  in  1  control write strobe.
- CTRL_I  in  6  [3:0] mode, [4] clear T_O (strobe only), [5] one-shot.
- CTRL_O  out  5  {one_shot, mode}.
- T_I  in  1  asynchronous trigger/event input.
- T_POL  in  1  active level of T_I (1 = high/rising).
- T_O  out  1  toggles on every timeout.
- T_O_PULSE  out  1  one-CLK pulse on every timeout.
- PULSE_MODE, EVENT_MODE  out  1  mode flags; the MFP GPIP interrupt logic uses them for masking.
- RUNNING  out  1  mode ≠ 0.
- SET_DATA_OUT  out  CNT_W  data register contents.

## Operation
- Mode 0: stopped. Modes 1–7: delay mode, with prescale ÷4, ÷10, ÷16, ÷50, ÷64, ÷100, ÷200. Mode 8: event mode. Modes 9–15: pulse mode, with the same prescale as mode−8.
- Prescaler:
  - Counts XCLK_EN cycles from 0 to N−1.
  - tick = XCLK_EN & (pre_cnt == N−1) & RUNNING; pre_cnt wraps to 0 on tick.
  - pre_cnt is held at 0 while stopped and cleared on every CTRL_WE.
- Trigger path:
  - T_I passes through a SYNC_STAGES flop synchroniser and is XORed with ~T_POL to give trig_s.
  - trig_d <= trig_s on CLK_EN.
  - edge = CLK_EN & trig_s & ~trig_d.
- count_q is registered:
  - delay mode: tick;
  - pulse mode: tick & trig_s;
  - event mode: edge;
  - otherwise 0.
- When count_q = 1:
  - If counter == 1: counter <= data, T_O toggles, T_O_PULSE = 1. If one-shot = 1, the mode is also cleared to 0 in the same cycle.
  - Otherwise: counter <= counter − 1. This wraps from 0 to 2^CNT_W−1, so data 0 gives a period of 2^CNT_W.
- DAT_WE: data <= DAT_I. The counter is also loaded only if stopped.
- Simultaneous DAT_WE and timeout reload: the reload takes DAT_I.
- CTRL_WE:
  - Updates mode and one-shot.
  - CTRL_I[4] = 1 clears T_O. If this coincides with a timeout toggle, the clear wins.
  - Simultaneous CTRL_WE and one-shot auto-stop: the CTRL_WE value wins.
- Stop/restart: the counter holds its value and resumes from it when restarted.
- Readback: on a DS rising edge (DS_q = 0, DS = 1), DAT_O <= counter.

## Timing
- Reset values of all registers and outputs are 0: T_O, T_O_PULSE, counter, data, mode, one_shot, DAT_O, pre_cnt, count_q, and both synchroniser chains.
- Reset asserted mid-count: the timer stops immediately. After release it stays stopped until CTRL_WE.
- Latency:
  - A tick or edge in cycle n sets count_q in cycle n+1.
  - The counter, T_O and T_O_PULSE update at the end of cycle n+1; T_O_PULSE is high during cycle n+2.
- T_O_PULSE is exactly one CLK wide. Back-to-back timeouts are possible when the period is one count and XCLK_EN is continuous.
- T_I to trig_s latency is SYNC_STAGES CLK cycles; edge additionally needs the next CLK_EN.
- DAT_O updates one cycle after the DS rising edge.
- Delay-mode period = N × data XCLK_EN cycles (data 0 counts as 2^CNT_W).

## Structure
- Package mfp_timer_pkg holds:
  - mode encodings (MODE_STOP, MODE_EVENT, pulse base);
  - the prescale table as a function mode → N−1;
  - control bit indices.
- One sub-module: mfp_timer_prescaler. Inputs CLK, RST_N, XCLK_EN, run, clr, div; output tick.
- The trigger synchroniser, counter and readback latch live in the top level.

## Test plan
- Delay mode: mode 1 (÷4), data 3, XCLK_EN held high → T_O_PULSE every 12 CLK; T_O toggles each time; DAT_O sampled via DS shows 3,2,1 sequence.
- Data 0, mode 1, XCLK_EN high → period 1024 CLK; counter wraps from 0 to 255.
- Event mode: T_POL 0, data 2, CLK_EN every 4th cycle, two falling T_I edges → one timeout. Rising edges are ignored.
- Pulse mode: mode 9, T_I high for 40 CLK then low → exactly 10 counts. Counting freezes while T_I is low.
- One-shot: mode 1, ctrl[5] = 1, data 2 → single T_O_PULSE after 8 CLK; RUNNING drops the same cycle; the counter holds at 2.
- Corner cases:
  - DAT_WE 5 while running → the counter is unaffected until the next reload, which uses 5.
  - DAT_WE coincident with timeout → the counter reloads with DAT_I.
  - RST_N pulsed mid-count → all outputs 0 asynchronously.
